pixel_ray_scheduler: RTL and testbench

Frame-level sequencer for the ray-tracing pipeline. Walks every screen pixel in raster order and issues one ray request per pixel to the intersection unit over a valid/ready handshake. Collects the tagged hit/location response and writes it, with its framebuffer address, to the colour stage, which feeds the colour determinator. Handles unit stalls, lost responses (timeout) and stale responses, so one slow or missing ray never corrupts the frame.

---
 rtl/pixel_ray_scheduler.sv | 235 +++++++++++++++++++++++
 tb/tb_pixel_ray_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_ray_scheduler.sv
// pixel_ray_scheduler
// Frame sequencer for the ray-tracing pipeline. Walks the screen in raster
// order, issues one tagged ray request per pixel, waits for the matching
// response (or gives up after TIMEOUT cycles) and hands the result plus its
// framebuffer address to the colour stage as a one-cycle write.
//
// Handshakes (both channels): a transfer happens on a rising edge where
// valid and ready are both high. The request payload (req_x_o, req_y_o,
// req_tag_o) is held stable while req_valid_o is high and req_ready_i is
// low. rsp_ready_o is high in every cycle after reset. Every accepted
// response either completes the pixel in WAIT (tag match) or is counted as
// stale and dropped.
module pixel_ray_scheduler #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int ADDR_W  = 19,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              continuous_i,
  // ray request channel
  output logic              req_valid_o,
  input  logic              req_ready_i,
  output logic [11:0]       req_x_o,
  output logic [11:0]       req_y_o,
  output logic [3:0]        req_tag_o,
  // ray response channel
  input  logic              rsp_valid_i,
  output logic              rsp_ready_o,
  input  logic [3:0]        rsp_tag_i,
  input  logic              rsp_hit_i,
  input  logic [35:0]       rsp_loc_i,
  // colour stage write port
  output logic              pix_we_o,
  output logic [ADDR_W-1:0] pix_addr_o,
  output logic              pix_hit_o,
  output logic [35:0]       pix_loc_o,
  // status
  output logic              busy_o,
  output logic              frame_done_o,
  output logic [15:0]       timeout_count_o,
  output logic [15:0]       stale_count_o,
  // debug: current FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 WRITE)
  output logic [1:0]        state_o
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [11:0]      X_LAST    = 12'(H_RES - 1);
  localparam logic [11:0]      Y_LAST    = 12'(V_RES - 1);
  localparam logic [15:0]      CNT_MAX   = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t state_q, state_d;

  // pixel position and running framebuffer address
  logic [11:0]       x_q, y_q;
  logic [ADDR_W-1:0] addr_q;
  // tag_q is the tag for the next request; out_tag_q is the tag in flight
  logic [3:0]        tag_q, out_tag_q;
  logic [CNT_W-1:0]  wait_cnt_q;

  // registered outputs
  logic              req_valid_q, req_valid_d;
  logic              busy_q, busy_d;
  logic              pix_we_q, pix_we_d;
  logic              frame_done_q, frame_done_d;
  logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
  logic              pix_hit_q;
  logic [35:0]       pix_loc_q;
  logic              rsp_ready_q;
  logic [15:0]       timeout_cnt_q, stale_cnt_q;

  // handshake and event decode
  logic req_hs, rsp_acc, rsp_match, wait_expire;
  logic last_x, last_y, last_pix;

  assign req_hs      = (state_q == S_ISSUE) && req_ready_i;
  assign rsp_acc     = rsp_valid_i && rsp_ready_q;
  assign rsp_match   = (state_q == S_WAIT) && rsp_acc && (rsp_tag_i == out_tag_q);
  // a matching response in the final wait cycle wins over the timeout
  assign wait_expire = (state_q == S_WAIT) && !rsp_match && (wait_cnt_q == WAIT_LAST);
  assign last_x      = (x_q == X_LAST);
  assign last_y      = (y_q == Y_LAST);
  assign last_pix    = last_x && last_y;

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_i) state_d = S_ISSUE;
      S_ISSUE: if (req_hs) state_d = S_WAIT;
      S_WAIT:  if (rsp_match || wait_expire) state_d = S_WRITE;
      S_WRITE: begin
        if (last_pix && !continuous_i) state_d = S_IDLE;
        else                           state_d = S_ISSUE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM output decode: outputs are computed from the next state so that
  // every output port comes straight from a flop
  always_comb begin
    req_valid_d  = (state_d == S_ISSUE);
    busy_d       = (state_d != S_IDLE);
    pix_we_d     = (state_d == S_WRITE);
    // WRITE is only entered from WAIT, where x/y still name the current pixel
    frame_done_d = (state_d == S_WRITE) && last_pix;
    pix_addr_d   = (state_d == S_WRITE) ? addr_q : pix_addr_q;
  end

  // output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      pix_we_q     <= 1'b0;
      frame_done_q <= 1'b0;
      pix_addr_q   <= '0;
      rsp_ready_q  <= 1'b0;
    end else begin
      req_valid_q  <= req_valid_d;
      busy_q       <= busy_d;
      pix_we_q     <= pix_we_d;
      frame_done_q <= frame_done_d;
      pix_addr_q   <= pix_addr_d;
      rsp_ready_q  <= 1'b1;
    end
  end

  // raster walk: position and address advance incrementally in WRITE
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
    end else if (state_q == S_IDLE && start_i) begin
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
    end else if (state_q == S_WRITE) begin
      if (last_x) begin
        x_q <= '0;
        if (last_y) begin
          y_q    <= '0;
          addr_q <= '0;
        end else begin
          y_q    <= y_q + 12'd1;
          addr_q <= addr_q + ADDR_W'(1);
        end
      end else begin
        x_q    <= x_q + 12'd1;
        addr_q <= addr_q + ADDR_W'(1);
      end
    end
  end

  // request tags and per-pixel wait counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_q      <= '0;
      out_tag_q  <= '0;
      wait_cnt_q <= '0;
    end else if (req_hs) begin
      out_tag_q  <= tag_q;
      tag_q      <= tag_q + 4'd1;
      wait_cnt_q <= '0;
    end else if (state_q == S_WAIT && !rsp_match && !wait_expire) begin
      wait_cnt_q <= wait_cnt_q + CNT_W'(1);
    end
  end

  // pixel result capture: response payload on a match, zeros on timeout
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pix_hit_q <= 1'b0;
      pix_loc_q <= '0;
    end else if (rsp_match) begin
      pix_hit_q <= rsp_hit_i;
      pix_loc_q <= rsp_loc_i;
    end else if (wait_expire) begin
      pix_hit_q <= 1'b0;
      pix_loc_q <= '0;
    end
  end

  // saturating timeout and stale-response counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timeout_cnt_q <= '0;
      stale_cnt_q   <= '0;
    end else begin
      if (wait_expire && timeout_cnt_q != CNT_MAX) begin
        timeout_cnt_q <= timeout_cnt_q + 16'd1;
      end
      if (rsp_acc && !rsp_match && stale_cnt_q != CNT_MAX) begin
        stale_cnt_q <= stale_cnt_q + 16'd1;
      end
    end
  end

  assign req_valid_o     = req_valid_q;
  assign req_x_o         = x_q;
  assign req_y_o         = y_q;
  assign req_tag_o       = tag_q;
  assign rsp_ready_o     = rsp_ready_q;
  assign pix_we_o        = pix_we_q;
  assign pix_addr_o      = pix_addr_q;
  assign pix_hit_o       = pix_hit_q;
  assign pix_loc_o       = pix_loc_q;
  assign busy_o          = busy_q;
  assign frame_done_o    = frame_done_q;
  assign timeout_count_o = timeout_cnt_q;
  assign stale_count_o   = stale_cnt_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_pixel_ray_scheduler.sv
// Bench for pixel_ray_scheduler on a 4x3 screen with TIMEOUT=8.
// Per-pixel behaviour and expected results come from a table of records;
// expected writes go into a queue at the request handshake and are popped
// when pix_we_o rises.
module tb_pixel_ray_scheduler;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int AW = 4;
  localparam int TO = 8;
  localparam int NP = H * V;
  localparam int EW = AW + 38;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              start, continuous;
  logic              req_valid, req_ready;
  logic [11:0]       req_x, req_y;
  logic [3:0]        req_tag;
  logic              rsp_valid, rsp_ready;
  logic [3:0]        rsp_tag;
  logic              rsp_hit;
  logic [35:0]       rsp_loc;
  logic              pix_we;
  logic [AW-1:0]     pix_addr;
  logic              pix_hit;
  logic [35:0]       pix_loc;
  logic              busy, frame_done;
  logic [15:0]       timeout_count, stale_count;
  logic [1:0]        state;

  pixel_ray_scheduler #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .continuous_i(continuous),
    .req_valid_o(req_valid), .req_ready_i(req_ready), .req_x_o(req_x),
    .req_y_o(req_y), .req_tag_o(req_tag),
    .rsp_valid_i(rsp_valid), .rsp_ready_o(rsp_ready), .rsp_tag_i(rsp_tag),
    .rsp_hit_i(rsp_hit), .rsp_loc_i(rsp_loc),
    .pix_we_o(pix_we), .pix_addr_o(pix_addr), .pix_hit_o(pix_hit),
    .pix_loc_o(pix_loc), .busy_o(busy), .frame_done_o(frame_done),
    .timeout_count_o(timeout_count), .stale_count_o(stale_count),
    .state_o(state)
  );

  // per-pixel stimulus and expected-result record
  typedef struct {
    int          stall;
    int          delay;
    bit          drop;
    int          stale_cyc;
    bit          hit;
    logic [35:0] loc;
    logic [11:0] exp_x;
    logic [11:0] exp_y;
    logic [AW-1:0] exp_addr;
    bit          exp_hit;
    logic [35:0] exp_loc;
    bit          exp_last;
    int          exp_lat;
  } pix_vec_t;

  pix_vec_t       vec [NP];
  logic [EW-1:0]  exp_q [$];

  int n_cmp = 0;
  int n_fail = 0;
  logic [3:0] exp_tag = 4'd0;
  logic [3:0] last_tag = 4'd0;
  int exp_writes = 0;
  logic [15:0] exp_stale = 16'd0;
  logic [15:0] exp_timeout = 16'd0;

  // free-running event counters, sampled on the rising edge
  int we_cnt = 0, fd_cnt = 0, busy_cnt = 0, fd_orphan = 0;
  always @(posedge clk) begin
    if (pix_we) we_cnt++;
    if (frame_done) fd_cnt++;
    if (busy) busy_cnt++;
    if (frame_done && !pix_we) fd_orphan++;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_vec(input int i, input int stall, input int delay, input bit drop,
                         input int stale_cyc, input bit hit, input logic [35:0] loc);
    vec[i].stall     = stall;
    vec[i].delay     = delay;
    vec[i].drop      = drop;
    vec[i].stale_cyc = stale_cyc;
    vec[i].hit       = hit;
    vec[i].loc       = loc;
    vec[i].exp_x     = 12'(i % H);
    vec[i].exp_y     = 12'(i / H);
    vec[i].exp_addr  = AW'(i);
    vec[i].exp_hit   = drop ? 1'b0 : hit;
    vec[i].exp_loc   = drop ? 36'd0 : loc;
    vec[i].exp_last  = (i == NP - 1);
    vec[i].exp_lat   = stall + 1 + (drop ? TO : delay + 1);
  endtask

  // unit responds in the first WAIT cycle, hit = x[0]
  task automatic fill_basic();
    for (int i = 0; i < NP; i++)
      set_vec(i, 0, 0, 1'b0, -1, (i % 2) == 1, {12'(i), 12'(i * 3), 12'(i + 100)});
  endtask

  // random delays plus a stall at (2,1), a dropped pixel 3 and a late
  // response for pixel 3 arriving in pixel 4's WAIT
  task automatic fill_corner();
    for (int i = 0; i < NP; i++)
      set_vec(i, 0, $urandom_range(0, 3), 1'b0, -1, 1'($urandom_range(0, 1)),
              {$urandom(), 4'($urandom_range(0, 15))});
    set_vec(3, 0, 0, 1'b1, -1, 1'b1, 36'hABC_DEF_123);
    set_vec(4, 0, 2, 1'b0, 0, 1'b0, 36'h111_222_333);
    set_vec(6, 5, 1, 1'b0, -1, 1'b1, 36'h666_777_888);
  endtask

  // driver + scoreboard for one pixel
  task automatic do_pixel(input pix_vec_t v);
    int n;
    int lat;
    logic [3:0] t;
    logic [EW-1:0] got;
    n = 0;
    while (!req_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!req_valid) begin
      check("req_valid_wait", 64'(req_valid), 64'd1);
      return;
    end
    check("req_x", 64'(req_x), 64'(v.exp_x));
    check("req_y", 64'(req_y), 64'(v.exp_y));
    check("req_tag", 64'(req_tag), 64'(exp_tag));
    lat = 0;
    for (int s = 0; s < v.stall; s++) begin
      req_ready = 1'b0;
      @(negedge clk);
      lat++;
      check("req_hold", 64'({req_valid, req_x, req_y, req_tag}),
            64'({1'b1, v.exp_x, v.exp_y, exp_tag}));
    end
    req_ready = 1'b1;
    @(negedge clk);
    lat++;
    req_ready = 1'b0;
    t = exp_tag;
    exp_tag = exp_tag + 4'd1;
    exp_q.push_back({v.exp_addr, v.exp_hit, v.exp_loc, v.exp_last});
    exp_writes++;
    n = 0;
    while (!pix_we && n < TO + 4) begin
      rsp_valid = 1'b0;
      if (!v.drop && n == v.delay) begin
        rsp_valid = 1'b1; rsp_tag = t; rsp_hit = v.hit; rsp_loc = v.loc;
      end else if (n == v.stale_cyc) begin
        rsp_valid = 1'b1; rsp_tag = last_tag; rsp_hit = 1'b1; rsp_loc = '1;
      end
      @(negedge clk);
      n++;
      lat++;
    end
    rsp_valid = 1'b0;
    last_tag = t;
    check("pix_latency", 64'(lat), 64'(v.exp_lat));
    if (!pix_we) begin
      check("pix_we_seen", 64'(pix_we), 64'd1);
    end else if (exp_q.size() == 0) begin
      check("exp_q_nonempty", 64'd0, 64'd1);
    end else begin
      got = exp_q.pop_front();
      check("pix_addr", 64'(pix_addr), 64'(got[EW-1 -: AW]));
      check("pix_hit", 64'(pix_hit), 64'(got[37]));
      check("pix_loc", 64'(pix_loc), 64'(got[36:1]));
      check("frame_done", 64'(frame_done), 64'(got[0]));
    end
  endtask

  task automatic start_frame();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_latency", 64'(req_valid), 64'd1);
  endtask

  task automatic run_frame(input bit poke_start);
    for (int i = 0; i < NP; i++) begin
      start = poke_start && i >= 1 && i <= 10;
      do_pixel(vec[i]);
    end
    start = 1'b0;
  endtask

  task automatic check_all_zero();
    check("rst_req_valid", 64'(req_valid), 64'd0);
    check("rst_req_xy_tag", 64'({req_x, req_y, req_tag}), 64'd0);
    check("rst_rsp_ready", 64'(rsp_ready), 64'd0);
    check("rst_pix", 64'({pix_we, pix_addr, pix_hit}), 64'd0);
    check("rst_pix_loc", 64'(pix_loc), 64'd0);
    check("rst_busy_done", 64'({busy, frame_done}), 64'd0);
    check("rst_counters", 64'({timeout_count, stale_count}), 64'd0);
    check("rst_state", 64'(state), 64'd0);
  endtask

  initial begin
    int b0, f0;
    start = 0; continuous = 0; req_ready = 0;
    rsp_valid = 0; rsp_tag = 0; rsp_hit = 0; rsp_loc = 0;

    // reset state
    repeat (2) @(negedge clk);
    check_all_zero();
    rst = 1'b0;
    @(negedge clk);
    check("rsp_ready_after_rst", 64'(rsp_ready), 64'd1);
    check("idle_busy", 64'(busy), 64'd0);

    // basic frame
    fill_basic();
    b0 = busy_cnt; f0 = fd_cnt;
    start_frame();
    run_frame(1'b0);
    @(negedge clk);
    check("busy_falls", 64'({busy, req_valid}), 64'd0);
    @(negedge clk);
    check("frame_cycles", 64'(busy_cnt - b0), 64'd36);
    check("frame_done_count1", 64'(fd_cnt - f0), 64'd1);

    // response while IDLE is stale
    rsp_valid = 1'b1; rsp_tag = 4'h5;
    @(negedge clk);
    rsp_valid = 1'b0;
    exp_stale++;
    @(negedge clk);
    check("stale_idle", 64'(stale_count), 64'(exp_stale));

    // stall, timeout, late response; start pulses mid-frame are ignored
    fill_corner();
    start_frame();
    run_frame(1'b1);
    exp_timeout++;
    exp_stale++;
    @(negedge clk);
    check("timeout_count", 64'(timeout_count), 64'(exp_timeout));
    check("stale_count", 64'(stale_count), 64'(exp_stale));
    check("idle_after_frame2", 64'(busy), 64'd0);

    // continuous mode: two back-to-back frames
    fill_basic();
    f0 = fd_cnt;
    continuous = 1'b1;
    start_frame();
    run_frame(1'b0);
    @(negedge clk);
    check("cont_next_req", 64'({req_valid, busy, req_x, req_y}), 64'({1'b1, 1'b1, 24'd0}));
    continuous = 1'b0;
    run_frame(1'b0);
    @(negedge clk);
    check("cont_idle", 64'(busy), 64'd0);
    @(negedge clk);
    check("frame_done_count2", 64'(fd_cnt - f0), 64'd2);

    // reset mid-frame at pixel 5
    f0 = fd_cnt;
    start_frame();
    for (int i = 0; i < 5; i++) do_pixel(vec[i]);
    for (int n = 0; n < 4 && !req_valid; n++) @(negedge clk);
    check("pix5_issue", 64'({req_valid, req_x, req_y}), 64'({1'b1, 12'd1, 12'd1}));
    rst = 1'b1;
    @(negedge clk);
    check_all_zero();
    rst = 1'b0;
    exp_tag = 4'd0; exp_stale = 16'd0; exp_timeout = 16'd0;
    @(negedge clk);
    check("rst_abandon_no_done", 64'(fd_cnt - f0), 64'd0);
    check("rst_idle", 64'({busy, rsp_ready}), 64'({1'b0, 1'b1}));
    start_frame();
    run_frame(1'b0);
    repeat (2) @(negedge clk);
    check("we_total", 64'(we_cnt), 64'(exp_writes));
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    check("frame_done_only_with_we", 64'(fd_orphan), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // hard stop if the bench ever wedges
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
